// File: rtl/mem_system_nway.sv
// N-way set-associative write-back, write-allocate cache with integrated controller.
// Round-robin victim per set, word-wide req/ack backing-memory port.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | waiting for a legal Rd^Wr request
//  S_LOOKUP | tag compare across all ways; hit completes here
//  S_WB     | writing the dirty victim line back, word 0 upward
//  S_FILL   | reading the requested line into the victim way
//  S_DONE   | miss completion pulse
module mem_system_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [15:0]       DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [15:0]       DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 1;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WOFF_W-1:0] off_q;
    logic [15:0]       din_q;
    logic              rd_q, wr_q;
    logic [WAY_W-1:0]  victim_q;
    logic              by_ptr_q;
    logic [WOFF_W-1:0] word_q;
    logic              gap_q;
    logic              err_q;

    logic [15:0]      data_arr [WAYS][SETS][LINE_WORDS];
    logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAYS-1:0]  dirty_q  [SETS];
    logic [WAY_W-1:0] rr_q     [SETS];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] vict_way;
    logic             vict_ptr;
    logic             accept;
    logic             illegal;
    logic             mem_active;
    logic             xfer;
    logic             last_word;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx_q][w] && (tag_arr[w][idx_q] == tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; the round-robin pointer only decides among full sets.
    always_comb begin
        vict_way = rr_q[idx_q];
        vict_ptr = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            if (vict_ptr && !valid_q[idx_q][w]) begin
                vict_way = WAY_W'(w);
                vict_ptr = 1'b0;
            end
        end
    end

    assign mem_active = ((state_q == S_WB) || (state_q == S_FILL)) && !gap_q;
    assign xfer       = mem_active && mem_ack;
    assign last_word  = (word_q == WOFF_W'(LINE_WORDS - 1));
    assign illegal    = (state_q == S_IDLE) && (Rd || Wr) && ((Rd && Wr) || Addr[0]);

    assign mem_req   = mem_active;
    assign mem_we    = mem_active && (state_q == S_WB);
    assign mem_addr  = !mem_active ? '0 :
                       (state_q == S_WB) ? {tag_arr[victim_q][idx_q], idx_q, word_q, 1'b0}
                                         : {tag_q, idx_q, word_q, 1'b0};
    assign mem_wdata = (mem_active && (state_q == S_WB)) ? data_arr[victim_q][idx_q][word_q] : '0;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        Done     = 1'b0;
        CacheHit = 1'b0;
        Stall    = 1'b0;
        DataOut  = '0;
        accept   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if ((Rd ^ Wr) && !Addr[0]) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    if (rd_q) DataOut = data_arr[hit_way][idx_q][off_q];
                    state_d  = S_IDLE;
                end else begin
                    Stall   = 1'b1;
                    state_d = (valid_q[idx_q][vict_way] && dirty_q[idx_q][vict_way]) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                Stall = 1'b1;
                if (xfer && last_word) state_d = S_FILL;
            end
            S_FILL: begin
                Stall = 1'b1;
                if (xfer && last_word) state_d = S_DONE;
            end
            S_DONE: begin
                Done = 1'b1;
                if (rd_q) DataOut = data_arr[victim_q][idx_q][off_q];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tag_q    <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            din_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            victim_q <= '0;
            by_ptr_q <= 1'b0;
            word_q   <= '0;
            gap_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= illegal;
            // Forces one idle cycle on the memory port after every acknowledged word.
            gap_q   <= xfer;
            if (accept) begin
                tag_q <= Addr[ADDR_W-1 -: TAG_W];
                idx_q <= Addr[OFF_W +: IDX_W];
                off_q <= Addr[1 +: WOFF_W];
                din_q <= DataIn;
                rd_q  <= Rd;
                wr_q  <= Wr;
            end
            if (state_q == S_LOOKUP) begin
                if (hit) begin
                    if (wr_q) dirty_q[idx_q][hit_way] <= 1'b1;
                end else begin
                    victim_q <= vict_way;
                    by_ptr_q <= vict_ptr;
                    word_q   <= '0;
                end
            end
            if (xfer) begin
                word_q <= last_word ? '0 : word_q + WOFF_W'(1);
                if ((state_q == S_FILL) && last_word) begin
                    valid_q[idx_q][victim_q] <= 1'b1;
                    dirty_q[idx_q][victim_q] <= wr_q;
                    if (by_ptr_q)
                        rr_q[idx_q] <= (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0
                                                                         : rr_q[idx_q] + WAY_W'(1);
                end
            end
        end
    end

    // Storage arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if ((state_q == S_LOOKUP) && hit && wr_q)
            data_arr[hit_way][idx_q][off_q] <= din_q;
        if ((state_q == S_FILL) && xfer) begin
            data_arr[victim_q][idx_q][word_q] <= (wr_q && (word_q == off_q)) ? din_q : mem_rdata;
            if (last_word) tag_arr[victim_q][idx_q] <= tag_q;
        end
    end

endmodule

// File: tb/tb_mem_system_nway.sv
// Directed bench for mem_system_nway (2 ways, 4 sets, 4-word lines) with a
// 3-cycle-latency backing memory model.
module tb_mem_system_nway;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Addr = '0;
    logic [15:0] DataIn = '0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [0:32767];
    logic        log_we   [$];
    logic [15:0] log_addr [$];
    logic        hold = 1'b0;
    int          cnt = 0;

    mem_system_nway #(.WAYS(2), .SETS(4), .LINE_WORDS(4), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            cnt = 0;
            mem_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (!hold) begin
            cnt++;
            if (cnt == 3) begin
                cnt = 0;
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr[15:1]];
                if (mem_we) mem[mem_addr[15:1]] = mem_wdata;
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] dout, output logic hit, output int lat);
        @(negedge clk);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        @(negedge clk);
        Rd = 1'b0; Wr = 1'b0;
        lat = 1;
        while (!Done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " done"}, Done, 1'b1);
        dout = DataOut;
        hit  = CacheHit;
    endtask

    task automatic check_words(input string tag, input int start, input logic we,
                               input logic [15:0] base);
        for (int k = 0; k < 4; k++) begin
            if (log_addr.size() > start + k) begin
                check({tag, " we"}, log_we[start+k], we);
                check({tag, " addr"}, log_addr[start+k], base + 16'(2*k));
            end
        end
    endtask

    initial begin
        logic [15:0] dout;
        logic        hit;
        int          lat;
        int          wait_cnt;

        for (int w = 0; w < 32768; w++) mem[w] = 16'h1000 + 16'(w);
        mem[8] = 16'd1; mem[9] = 16'd2; mem[10] = 16'd3; mem[11] = 16'd4;

        #1;
        check("rst Done", Done, 1'b0);
        check("rst Stall", Stall, 1'b0);
        check("rst err", err, 1'b0);
        check("rst mem_req", mem_req, 1'b0);
        check("rst DataOut", DataOut, 16'h0);
        check("rst CacheHit", CacheHit, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Cold load, then hit in the same line
        access("t1 cold", 1'b1, 1'b0, 16'h0010, 16'h0, dout, hit, lat);
        check("t1 cold hit", hit, 1'b0);
        check("t1 cold data", dout, 16'd1);
        check("t1 nxfers", log_addr.size(), 4);
        check_words("t1 rd", 0, 1'b0, 16'h0010);
        access("t1 reload", 1'b1, 1'b0, 16'h0014, 16'h0, dout, hit, lat);
        check("t1 reload hit", hit, 1'b1);
        check("t1 reload data", dout, 16'd3);
        check("t1 reload lat", lat, 1);

        // Store miss into a cleared cache merges DataIn
        do_reset();
        log_we.delete(); log_addr.delete();
        access("t2 store", 1'b0, 1'b1, 16'h0012, 16'hBEEF, dout, hit, lat);
        check("t2 store hit", hit, 1'b0);
        check("t2 store dout", dout, 16'h0);
        check("t2 nxfers", log_addr.size(), 4);
        check_words("t2 rd", 0, 1'b0, 16'h0010);
        access("t2 load", 1'b1, 1'b0, 16'h0012, 16'h0, dout, hit, lat);
        check("t2 load hit", hit, 1'b1);
        check("t2 load data", dout, 16'hBEEF);
        check("t2 no write", log_addr.size(), 4);
        check("t2 mem intact", mem[9], 16'd2);

        // Two dirty lines in set 1, then two conflicting misses
        access("t3 stA", 1'b0, 1'b1, 16'h0028, 16'hAAAA, dout, hit, lat);
        access("t3 stB", 1'b0, 1'b1, 16'h0048, 16'hBBBB, dout, hit, lat);
        log_we.delete(); log_addr.delete();
        access("t3 ldC", 1'b1, 1'b0, 16'h0068, 16'h0, dout, hit, lat);
        check("t3 C hit", hit, 1'b0);
        check("t3 C data", dout, 16'h1034);
        check("t3 C nxfers", log_addr.size(), 8);
        check_words("t3 wbA", 0, 1'b1, 16'h0028);
        check_words("t3 rdC", 4, 1'b0, 16'h0068);
        check("t3 wbA word0", mem[16'h14], 16'hAAAA);
        check("t3 wbA word1", mem[16'h15], 16'h1015);
        log_we.delete(); log_addr.delete();
        access("t3 ldD", 1'b1, 1'b0, 16'h0088, 16'h0, dout, hit, lat);
        check("t3 D hit", hit, 1'b0);
        check("t3 D data", dout, 16'h1044);
        check("t3 D nxfers", log_addr.size(), 8);
        check_words("t3 wbB", 0, 1'b1, 16'h0048);
        check_words("t3 rdD", 4, 1'b0, 16'h0088);
        check("t3 wbB word0", mem[16'h24], 16'hBBBB);

        // Illegal requests
        log_we.delete(); log_addr.delete();
        @(negedge clk);
        Rd = 1'b1; Wr = 1'b1; Addr = 16'h0068;
        @(negedge clk);
        check("t4 rdwr err", err, 1'b1);
        check("t4 rdwr stall", Stall, 1'b0);
        check("t4 rdwr done", Done, 1'b0);
        Rd = 1'b0; Wr = 1'b0;
        @(negedge clk);
        check("t4 err pulse", err, 1'b0);
        Rd = 1'b1; Addr = 16'h0011;
        @(negedge clk);
        check("t4 odd err", err, 1'b1);
        check("t4 odd stall", Stall, 1'b0);
        Rd = 1'b0;
        @(negedge clk);
        check("t4 odd pulse", err, 1'b0);
        check("t4 no mem_req", mem_req, 1'b0);
        access("t4 ldC", 1'b1, 1'b0, 16'h0068, 16'h0, dout, hit, lat);
        check("t4 C hit", hit, 1'b1);
        check("t4 C data", dout, 16'h1034);
        access("t4 ldD", 1'b1, 1'b0, 16'h0088, 16'h0, dout, hit, lat);
        check("t4 D hit", hit, 1'b1);
        check("t4 D data", dout, 16'h1044);
        check("t4 no xfers", log_addr.size(), 0);

        // Reset during the second fill word
        @(negedge clk);
        Rd = 1'b1; Addr = 16'h0100;
        @(negedge clk);
        Rd = 1'b0;
        wait_cnt = 0;
        while (!(log_addr.size() >= 1 && mem_req && !mem_ack) && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("t5 reached word2", mem_addr, 16'h0102);
        rst_n = 1'b0;
        #1;
        check("t5 rst mem_req", mem_req, 1'b0);
        check("t5 rst Stall", Stall, 1'b0);
        check("t5 rst Done", Done, 1'b0);
        check("t5 rst mem_addr", mem_addr, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        log_we.delete(); log_addr.delete();
        access("t5 reload", 1'b1, 1'b0, 16'h0100, 16'h0, dout, hit, lat);
        check("t5 hit", hit, 1'b0);
        check("t5 data", dout, 16'h1080);
        check("t5 nxfers", log_addr.size(), 4);
        check_words("t5 rd", 0, 1'b0, 16'h0100);

        // Memory stalls for 20 cycles while inputs toggle
        log_we.delete(); log_addr.delete();
        hold = 1'b1;
        @(negedge clk);
        Rd = 1'b1; Addr = 16'h0180;
        @(negedge clk);
        Rd = 1'b0;
        wait_cnt = 0;
        while (!mem_req && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            Rd = i[0]; Wr = ~i[0]; Addr = 16'h0028; DataIn = 16'h5555;
            @(negedge clk);
            check("t6 mem_req held", mem_req, 1'b1);
            check("t6 mem_addr held", mem_addr, 16'h0180);
            check("t6 stall held", Stall, 1'b1);
        end
        Rd = 1'b0; Wr = 1'b0;
        hold = 1'b0;
        lat = 0;
        while (!Done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("t6 done", Done, 1'b1);
        check("t6 hit", CacheHit, 1'b0);
        check("t6 data", DataOut, 16'h10C0);
        check("t6 nxfers", log_addr.size(), 4);
        check_words("t6 rd", 0, 1'b0, 16'h0180);
        @(negedge clk);
        check("t6 idle after", Stall, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
